riscv_test_monitor: RTL
=======================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesizable pass/fail monitor sitting directly downstream of the pipelined Core. It consumes the
//  fetch PC and register writeback streams, shadows x3 (gp, the riscv-tests TESTNUM register) and
//  detects the end-of-test halt address. It reports a sticky pass/fail/timeout verdict with cycle count,
//  replacing ad-hoc hierarchical peeks in per-test benches (rv32ui-p-*).
// PARAMETERS
//  HALT_PC        32'h44    fetch address that marks end of test
//  TIMEOUT_CYCLES 6000      RUN cycles before a TIMEOUT verdict (>=1)
//  CNT_W          32        width of cycle_count (and instret when enabled)
// PORTS
//  clk            in   1      clock, all logic on rising edge
//  rst            in   1      synchronous, active-low reset
//  if_valid       in   1      if_pc carries a real fetch this cycle
//  if_pc          in   32     fetch-stage PC
//  wb_en          in   1      register-file write this cycle
//  wb_addr        in   5      destination register index
//  wb_data        in   32     value written
//  done           out  1      verdict reached (sticky until reset)
//  pass           out  1      done and gp==1
//  fail           out  1      done and gp!=1 (not timeout)
//  timeout        out  1      TIMEOUT_CYCLES elapsed without halt
//  fail_testnum   out  31     gp[31:1] captured at halt (failing test number)
//  cycle_count    out  CNT_W  RUN cycles elapsed, frozen at verdict
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, gp_shadow=0, all outputs 0, cycle_count=0. Reset mid-test
//   aborts any run and clears verdicts the same edge; no output change until rst returns high.
//  States: IDLE -> RUN on first cycle with if_valid=1 (that cycle counts; cycle_count=1 next cycle).
//   RUN: cycle_count += 1 each cycle. RUN -> DONE when if_valid && if_pc==HALT_PC.
//   RUN -> TOUT when cycle_count == TIMEOUT_CYCLES-1 and no halt this cycle.
//   DONE, TOUT: terminal; only reset exits. Further inputs ignored.
//  gp_shadow: updated on wb_en && wb_addr==3 in IDLE and RUN. Writes to x0 or other regs ignored.
//  Verdict (registered, visible the cycle after halt fetch): pass = (gp_eff==1); fail = !pass;
//   fail_testnum = gp_eff[31:1]. gp_eff = wb_data if a gp write coincides with the halt cycle,
//   else gp_shadow (same-cycle bypass required).
//  Halt and timeout in the same cycle: halt wins (DONE, timeout stays 0).
//  if_pc==HALT_PC with if_valid=0 is ignored (bubble/flush); halt only counts in RUN, never in IDLE.
//  done = pass|fail|timeout; exactly one of pass/fail/timeout is 1 once done=1.
//  cycle_count does not wrap: saturates at all-ones if CNT_W too small.
// CONFIGURATION
//  TESTMON_INSTRET_EN defined: adds input `retire` (1b, one instruction retired) and output
//   `instret` (CNT_W, count of retire pulses in RUN incl. halt cycle, frozen at verdict, 0 on reset).
//  Undefined: neither port exists; no instret logic is synthesized.
// TESTING
//  1 gp<=1 via wb(addr 3) at cycle 20, valid fetch of 0x44 at cycle 40 -> pass=1,done=1,cycle_count=40 next cycle.
//  2 gp<=0x7 (test 3 failed), halt fetch -> fail=1, pass=0, fail_testnum=3.
//  3 gp<=1 written in same cycle as halt fetch with prior gp=5 -> pass=1 (bypass).
//  4 never fetch 0x44, TIMEOUT_CYCLES=100 -> timeout=1 after 100 RUN cycles, cycle_count=100, pass=fail=0.
//  5 if_pc=0x44 with if_valid=0 at cycle 10, then real halt at 30 -> verdict at 30 only; halt on
//    timeout cycle -> DONE not TOUT.
//  6 rst low mid-RUN then high; after verdict, rst low -> all outputs 0, gp_shadow 0, new run from IDLE;
//    with TESTMON_INSTRET_EN, 25 retire pulses -> instret=25.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests runs: shadows gp (x3), detects the halt fetch and latches a sticky verdict.
// Define TESTMON_INSTRET_EN to add the retire input and the instret counter output.
`timescale 1ns/1ps
module riscv_test_monitor #(
  parameter logic [31:0] HALT_PC        = 32'h44,
  parameter int          TIMEOUT_CYCLES = 6000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
`ifdef TESTMON_INSTRET_EN
  input  logic             retire,
  output logic [CNT_W-1:0] instret,
`endif
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_testnum,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TOUT} state_t;

  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_gp_shadow;
  logic               r_gp_one;
  logic [30:0]        r_fail_testnum;
  logic [CNT_W-1:0]   r_cycle_count;

  logic               w_active;
  logic               w_halt;
  logic               w_tout_hit;
  logic               w_gp_wr;
  logic [31:0]        w_gp_eff;
  logic               w_count_en;

  assign w_active   = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_halt     = (r_state == S_RUN) && if_valid && (if_pc == HALT_PC);
  assign w_tout_hit = (r_state == S_RUN) && !w_halt && (r_cycle_count >= TOUT_LAST);
  assign w_gp_wr    = w_active && wb_en && (wb_addr == 5'd3);
  // A gp write landing on the halt cycle must decide the verdict, so bypass the shadow.
  assign w_gp_eff   = w_gp_wr ? wb_data : r_gp_shadow;
  assign w_count_en = ((r_state == S_IDLE) && if_valid) || (r_state == S_RUN);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (if_valid)        w_next = S_RUN;
      S_RUN: begin
        if (w_halt)                w_next = S_DONE;
        else if (w_tout_hit)       w_next = S_TOUT;
      end
      S_DONE:                      w_next = S_DONE;
      S_TOUT:                      w_next = S_TOUT;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done         = (r_state == S_DONE) || (r_state == S_TOUT);
    pass         = (r_state == S_DONE) && r_gp_one;
    fail         = (r_state == S_DONE) && !r_gp_one;
    timeout      = (r_state == S_TOUT);
    fail_testnum = r_fail_testnum;
    cycle_count  = r_cycle_count;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gp_shadow    <= '0;
      r_gp_one       <= 1'b0;
      r_fail_testnum <= '0;
      r_cycle_count  <= '0;
    end else begin
      if (w_gp_wr) r_gp_shadow <= wb_data;
      if (w_halt) begin
        r_gp_one       <= (w_gp_eff == 32'd1);
        r_fail_testnum <= w_gp_eff[31:1];
      end
      // Saturate rather than wrap so a narrow counter never fakes an early count.
      if (w_count_en && (r_cycle_count != {CNT_W{1'b1}}))
        r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

`ifdef TESTMON_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (!rst) r_instret <= '0;
    else if ((r_state == S_RUN) && retire && (r_instret != {CNT_W{1'b1}}))
      r_instret <= r_instret + 1'b1;
  end

  assign instret = r_instret;
`endif

endmodule
